// File: rtl/visor_pkg.sv
// Shared types and constants for the subtractor result display.
// Optional feature macro: VISOR_PARPADEO_EN (see visor_restador.sv).
package visor_pkg;

  typedef enum logic {
    VACIO   = 1'b0,
    MOSTRAR = 1'b1
  } estado_t;

  // Hex glyphs, active-high, bit order {g,f,e,d,c,b,a}; index 15 first.
  localparam logic [15:0][6:0] HEX_GLIFOS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_MENOS   = 7'b1000000;
  localparam logic [6:0] SEG_APAGADO = 7'b0000000;

  localparam int BLINK_TOGGLES = 256;

endpackage

// File: rtl/hex_a_7seg.sv
// Combinational 4-bit to 7-segment decoder, active-high {g,f,e,d,c,b,a}.
module hex_a_7seg
  import visor_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_GLIFOS[hex];

endmodule

// File: rtl/visor_restador.sv
// Sign/magnitude display stage for the 4-bit subtractor.
// Captures {Cout,S} on cargar, shows |A-B| in hex on digit 0 and the sign
// on digit 1 of a 2-digit multiplexed 7-segment display.
// Optional feature macro: VISOR_PARPADEO_EN (negative results blink).
module visor_restador
  import visor_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVO_BAJO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] S,
  input  logic       Cout,
  input  logic       cargar,
  input  logic       borrar,
  output logic       valido,
  output logic       negativo,
  output logic [3:0] magnitud,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_FIN = CW'(REFRESH_DIV - 1);

  // XOR masks that turn active-high internal values into pin polarity;
  // the masks themselves are the "everything off" pin values.
  localparam logic [6:0] MASK_SEG = {7{ACTIVO_BAJO}};
  localparam logic [1:0] MASK_AN  = {2{ACTIVO_BAJO}};

  // Two's-complement magnitude of a borrowed difference.
  function automatic logic [3:0] magnitud_de(input logic [3:0] dif,
                                             input logic       borrow);
    logic [3:0] neg;
    neg = ~dif + 4'd1;
    return borrow ? neg : dif;
  endfunction

  estado_t         estado, estado_sig;
  logic            captura;
  logic [CW-1:0]   cnt;
  logic            dsel;
  logic            fin_periodo;
  logic            ocultar;
  logic [6:0]      glifo_mag;
  logic [6:0]      seg_c;
  logic [1:0]      an_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) estado <= VACIO;
    else     estado <= estado_sig;
  end

  // Next state; borrar outranks cargar.
  always_comb begin
    estado_sig = estado;
    captura    = 1'b0;
    if (borrar) begin
      estado_sig = VACIO;
    end else if (cargar) begin
      estado_sig = MOSTRAR;
      captura    = 1'b1;
    end
  end

  // Capture stage: sign and magnitude of the subtractor result.
  always_ff @(posedge clk) begin
    if (rst) begin
      valido   <= 1'b0;
      negativo <= 1'b0;
      magnitud <= 4'd0;
    end else if (borrar) begin
      valido   <= 1'b0;
    end else if (captura) begin
      valido   <= 1'b1;
      negativo <= Cout;
      magnitud <= magnitud_de(S, Cout);
    end
  end

  assign fin_periodo = (estado == MOSTRAR) && (cnt == CNT_FIN);

  // Scan counter and digit select; idle at zero while blank so every load
  // from blank starts on the magnitude digit. Reloads keep the phase.
  always_ff @(posedge clk) begin
    if (rst || estado == VACIO) begin
      cnt  <= '0;
      dsel <= 1'b0;
    end else if (fin_periodo) begin
      cnt  <= '0;
      dsel <= ~dsel;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

`ifdef VISOR_PARPADEO_EN
  logic [7:0] n_tog;
  logic       parpadeo;

  // Blink bit flips after BLINK_TOGGLES digit-select toggles.
  always_ff @(posedge clk) begin
    if (rst || borrar || cargar) begin
      n_tog    <= 8'd0;
      parpadeo <= 1'b0;
    end else if (fin_periodo) begin
      n_tog <= n_tog + 8'd1;
      if (n_tog == 8'(BLINK_TOGGLES - 1)) parpadeo <= ~parpadeo;
    end
  end

  assign ocultar = negativo & parpadeo;
`else
  assign ocultar = 1'b0;
`endif

  hex_a_7seg u_hex (
    .hex (magnitud),
    .seg (glifo_mag)
  );

  // Active-high digit content from captured values and scan position.
  always_comb begin
    seg_c = SEG_APAGADO;
    an_c  = 2'b00;
    if (estado == MOSTRAR) begin
      if (!dsel) begin
        an_c  = 2'b01;
        seg_c = glifo_mag;
      end else begin
        an_c  = 2'b10;
        seg_c = negativo ? SEG_MENOS : SEG_APAGADO;
      end
      if (ocultar) an_c = 2'b00;
    end
  end

  // Display output stage; polarity applied here only.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= MASK_SEG;
      an  <= MASK_AN;
    end else begin
      seg <= seg_c ^ MASK_SEG;
      an  <= an_c ^ MASK_AN;
    end
  end

endmodule

// File: tb/tb_visor_restador.sv
// Scoreboard bench for visor_restador (REFRESH_DIV=4, active-low pins).
module tb_visor_restador;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cargar = 1'b0;
  logic       borrar = 1'b0;
  logic       Cout = 1'b0;
  logic [3:0] S = 4'd0;
  logic       valido, negativo;
  logic [3:0] magnitud;
  logic [6:0] seg;
  logic [1:0] an;

  visor_restador #(.REFRESH_DIV(RD), .ACTIVO_BAJO(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .S        (S),
    .Cout     (Cout),
    .cargar   (cargar),
    .borrar   (borrar),
    .valido   (valido),
    .negativo (negativo),
    .magnitud (magnitud),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic       val;
    logic       neg;
    logic [3:0] mag;
    logic [6:0] seg;
    logic [1:0] an;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: what has been captured and how long it has been shown.
  bit m_show  = 0;
  int m_ticks = 0;
  bit m_val   = 0;
  bit m_neg   = 0;
  int m_mag   = 0;

  // Active-high glyph for a hex value, segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glifo(input int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      10: return 7'b1110111; 11: return 7'b1111100;
      12: return 7'b0111001; 13: return 7'b1011110;
      14: return 7'b1111001; default: return 7'b1110001;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  // One clock of stimulus: operands a,b feed the subtractor result.
  task automatic paso(input bit r, input bit ld, input bit clr, input int a, input int b);
    exp_t e;
    int   diff;
    diff   = a - b;
    rst    = r;
    cargar = ld;
    borrar = clr;
    S      = 4'(diff);
    Cout   = (a < b);
    e.stamp = cyc + 1;
    // Display reflects what was captured before this edge.
    if (r || !m_show) begin
      e.an  = 2'b11;
      e.seg = 7'b1111111;
    end else if (((m_ticks / RD) % 2) == 0) begin
      e.an  = 2'b10;
      e.seg = ~glifo(m_mag);
    end else begin
      e.an  = 2'b01;
      e.seg = m_neg ? 7'b0111111 : 7'b1111111;
    end
    if (r) begin
      m_show = 0; m_ticks = 0; m_val = 0; m_neg = 0; m_mag = 0;
    end else begin
      if (m_show) m_ticks++;
      if (clr) begin
        m_show = 0;
        m_val  = 0;
      end else if (ld) begin
        if (!m_show) m_ticks = 0;
        m_show = 1;
        m_val  = 1;
        m_neg  = (a < b);
        m_mag  = (diff < 0) ? -diff : diff;
      end
    end
    e.val = m_val;
    e.neg = m_neg;
    e.mag = 4'(m_mag);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) paso(0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every expected entry due at this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].stamp <= cyc) begin
        mon_e = q.pop_front();
        if (mon_e.stamp != cyc) begin
          chk("sello", 8'(mon_e.stamp), 8'(cyc));
        end else begin
          chk("valido",   {7'd0, valido},   {7'd0, mon_e.val});
          chk("negativo", {7'd0, negativo}, {7'd0, mon_e.neg});
          chk("magnitud", {4'd0, magnitud}, {4'd0, mon_e.mag});
          chk("seg",      {1'b0, seg},      {1'b0, mon_e.seg});
          chk("an",       {6'd0, an},       {6'd0, mon_e.an});
        end
      end
    end
  end

  // Stimulus.
  initial begin
    paso(1, 0, 0, 0, 0);
    paso(1, 0, 0, 0, 0);
    idle(2);
    paso(0, 1, 0, 5, 2);       // positive 3
    idle(10);
    paso(0, 1, 0, 2, 5);       // reload negative 3, mid-period
    idle(6);
    paso(0, 1, 0, 0, 15);      // magnitude 15
    idle(9);
    paso(0, 1, 1, 7, 0);       // clear wins over load
    idle(3);
    paso(0, 1, 0, 9, 4);
    idle(5);                   // now on the sign digit
    paso(1, 0, 0, 0, 0);       // reset mid-scan
    paso(0, 1, 0, 3, 3);       // zero result
    idle(6);
    paso(0, 1, 0, 15, 0);
    idle(4);
    for (int i = 0; i < 400; i++) begin
      paso($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)));
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("cola_vacia", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/visor_restador.md
Name: visor_restador

Overview:
Downstream stage of the 4-bit subtractor: captures its difference S and borrow Cout on a load strobe, and converts the pair to sign plus magnitude. It drives a 2-digit multiplexed 7-segment display: digit 0 shows the magnitude in hex, digit 1 shows the sign. It is the board-facing output of the subtraction datapath.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays lit before the scan advances (min 2)
ACTIVO_BAJO, 1, 1 = seg and an are active-low; 0 = active-high

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
S  input  4  difference from subtractor (A-B mod 16)
Cout  input  1  borrow from subtractor; 1 = A<B
cargar  input  1  load strobe, sampled each rising edge
borrar  input  1  clear strobe; blanks the display
valido  output  1  high while a captured result is displayed
negativo  output  1  registered sign of captured result
magnitud  output  4  registered |A-B|, range 0..15
seg  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVO_BAJO
an  output  2  digit enables, an[0]=magnitude, an[1]=sign, polarity per ACTIVO_BAJO

Behaviour:
- Reset values: valido=0, negativo=0, magnitud=0, all seg and an inactive, scan counter=0, digit select=0, state VACIO.
- FSM, two states:
  - VACIO: display blank.
  - MOSTRAR: scanning.
  - VACIO->MOSTRAR on cargar. MOSTRAR->MOSTRAR on cargar (reload). Any state->VACIO on borrar.
- Priority: borrar wins over cargar in the same cycle. rst wins over everything.
- Capture on cargar at edge t:
  - negativo=Cout and magnitud are valid at t+1.
  - magnitud = S when Cout=0. When Cout=1, magnitud = (~S+1) truncated to 4 bits.
  - valido=1 at t+1.
- Display outputs: seg and an are registered from the captured values, so a new value appears at t+2.
- Scan counter:
  - Counts 0..REFRESH_DIV-1 only in MOSTRAR.
  - At terminal count it wraps to 0 and toggles the digit select.
  - Held at 0 in VACIO.
  - A reload does not reset the counter or the digit select.
- Digit encodings:
  - Digit 0 uses standard hex glyphs 0-F (lowercase b, d).
  - Digit 1 shows '-' (segment g only) when negativo=1, otherwise all segments off, with an[1] still asserted.
- Exactly one an bit is active in MOSTRAR; none in VACIO.
- rst mid-scan: at the next edge all outputs return to their reset values.

Optional Feature:
VISOR_PARPADEO_EN
- Defined: a blink bit toggles every 256 digit-select toggles. While negativo=1 and the blink bit is 1, both anodes are forced inactive; positive results never blink. The blink bit resets to 0 on rst, borrar, and cargar.
- Undefined: no blink logic; display steady.

Decomposition:
- Package visor_pkg holds:
  - state typedef {VACIO, MOSTRAR}
  - 16-entry hex glyph constants (active-high form)
  - SEG_MENOS = 7'b1000000, SEG_APAGADO = 7'b0000000
  - BLINK_TOGGLES = 256
- Polarity inversion is applied once, at the output registers.
- One sub-module: hex_a_7seg, a combinational 4-bit to 7-bit active-high decoder, instantiated for digit 0.

Test Plan (REFRESH_DIV=4, ACTIVO_BAJO=1):
- Reset: rst high 2 cycles -> an=2'b11, seg=7'b1111111, valido=0, magnitud=0.
- Positive load: cargar with S=4'h3, Cout=0 (5-2) -> magnitud=3, negativo=0 at t+1. While an=2'b10, seg=7'b0110000; while an=2'b01, seg=7'b1111111.
- Negative load: cargar with S=4'hD, Cout=1 (2-5) -> magnitud=3, negativo=1. Sign-digit seg=7'b0111111; S=4'h1, Cout=1 gives magnitud=15, glyph F=7'b0001110.
- Scan timing: after load, an holds 2'b10 for 4 cycles, then 2'b01 for 4 cycles, repeating. A reload mid-period keeps the phase.
- Clear priority: cargar and borrar together with S=4'h7 -> VACIO, an=2'b11, valido=0, magnitud unchanged.
- Reset mid-operation: rst during an=2'b01 -> next edge an=2'b11, counter=0. A following load restarts with an=2'b10.
